dmem_responder: RTL and testbench
=================================

# dmem_responder

Latency-configurable data-memory responder: the target side of the CPU load/store path. It accepts one word-addressed request at a time over a valid/ready request channel, performs a read or byte-masked write into an internal word array, and returns the result over a valid/ready response channel. It replaces the zero-wait combinational data memory so that the pipeline's MEM stage can be exercised against a slow memory.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 2, cycles spent in WAIT per request; ≥ 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for a store; bit i covers bits [8i+7:8i]; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errored requests.
- rsp_err  out  1  request was rejected (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/wdata/be, load counter with LATENCY−1, go to WAIT.
- WAIT: req_ready = 0, rsp_valid = 0. If counter == 0, perform the access, load rsp_rdata and rsp_err, go to RESP; otherwise decrement the counter.
- Access: word index = req_addr[log2(DEPTH)+1:2]. Load: rsp_rdata = mem[index]. Store: for each set be bit, update that byte; rsp_rdata = 0. A store with be = 0 is legal and changes nothing.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable until the handshake. On rsp_ready, go to IDLE. rsp_ready while rsp_valid = 0 is ignored.
- Request inputs are ignored outside IDLE; only the latched copy is used.
- Stores commit in the WAIT→RESP transition. A load accepted after a store's response therefore sees the stored data.

## Timing
- Reset (rst = 0 at an edge): state = IDLE, every mem word = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. req_ready = 1 from the first cycle with rst = 1.
- Reset mid-transaction: any pending request is discarded and no write is committed.
- Request accepted in cycle T: rsp_valid first high in cycle T+1+LATENCY.
- Response accepted in cycle R: req_ready is high in R+1. There is no same-cycle turnaround.
- Minimum spacing between request acceptances: LATENCY+2 cycles.
- Outputs are driven directly from state and registers. There is no combinational path from inputs to outputs.

## Configuration
- DMEM_RESP_ERR_EN defined: rsp_err = 1 when req_addr[1:0] ≠ 0 or req_addr ≥ 4·DEPTH. An errored request performs no write, returns rsp_rdata = 0, and has the same timing as a normal request.
- DMEM_RESP_ERR_EN undefined: rsp_err is tied to 0. Address bits [1:0] and all bits above the index are ignored, so addresses alias modulo 4·DEPTH.

## Test plan
- Reset then load: release rst; load addr 0x10 with LATENCY = 2 → rsp_valid in cycle T+3, rsp_rdata = 0x00000000, rsp_err = 0.
- Store/load round-trip: store 0xDEADBEEF at 0x20 with be = 4'hF, then load 0x20 → rsp_rdata = 0xDEADBEEF.
- Byte mask: with 0x20 = 0xDEADBEEF, store 0x11223344 with be = 4'b0101, then load 0x20 → rsp_rdata = 0xDE22BE44.
- Backpressure: hold rsp_ready = 0 for 5 cycles → rsp_valid stays 1, rsp_rdata stable, req_ready = 0 throughout; raise rsp_ready → req_ready = 1 in the next cycle.
- Reset mid-op: accept a store of 0x5 to 0x8, drop rst during WAIT, then load 0x8 → rsp_rdata = 0 and no stale rsp_valid.
- Error / alias with DEPTH = 256: load 0x402 with the macro defined → rsp_err = 1, rsp_rdata = 0. Without the macro, store 0xA5A5A5A5 at 0x4 then load 0x406 → rsp_rdata = 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait cycles, then a held response.
// Optional build macro DMEM_RESP_ERR_EN flags misaligned or out-of-range addresses via rsp_err.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [IdxW-1:0]   idx;
  logic              acc_err;
  logic              mem_we;
  logic [31:0]       mem_rd;
  logic [31:0]       mem_wdata;

  assign idx    = addr_q[IdxW+1:2];
  assign mem_rd = mem_q[idx];

`ifdef DMEM_RESP_ERR_EN
  assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (IdxW + 2)) != 32'd0);
`else
  // Without error checking the low and upper address bits simply alias.
  logic unused_addr;
  assign unused_addr = ^{addr_q[31:IdxW+2], addr_q[1:0]};
  assign acc_err     = 1'b0;
`endif

  always_comb begin
    mem_wdata = mem_rd;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) mem_wdata[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          err_d   = acc_err;
          rdata_d = (we_q || acc_err) ? 32'd0 : mem_rd;
          mem_we  = we_q && !acc_err;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset clears the whole array; a store in flight at reset never reaches it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses, monitor pops on handshake.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned vcyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt = 0;
  int   n_exp = 0;
  logic prev_valid = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: latency on rising rsp_valid, data/err on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
        end else begin
          check("rsp_latency", cyc, sb[0].vcyc);
        end
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        check("rsp_rdata", rsp_rdata, sb[0].rdata);
        check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        void'(sb.pop_front());
        rsp_cnt <= rsp_cnt + 1;
      end
      prev_valid <= rsp_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                       input bit push);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (push) begin
      sb.push_back('{rdata: exp_rdata, err: exp_err, vcyc: cyc + 1 + LATENCY});
      n_exp++;
    end
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must not leak into the latched request.
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h0BAD_0BAD;
    req_be    = 4'hF;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && rsp_cnt < n_exp; i++) @(negedge clk);
    checks++;
    if (rsp_cnt < n_exp) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_cnt, n_exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    issue(we, addr, wdata, be, exp_rdata, exp_err, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
    xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
    xfer(1'b1, 32'h20, 32'h7700_0000, 4'b1000, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h7722_BE44, 1'b0);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h7722_BE44, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h7722_BE44);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_req_ready_after", 32'(req_ready), 32'd1);
    check("bp_rsp_valid_after", 32'(rsp_valid), 32'd0);
    wait_done();

    // Reset during WAIT drops the store.
    issue(1'b1, 32'h8, 32'h5, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("midreset_req_ready", 32'(req_ready), 32'd1);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

`ifdef DMEM_RESP_ERR_EN
    xfer(1'b0, 32'h402, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(1'b1, 32'h22, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    xfer(1'b1, 32'h420, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
`else
    xfer(1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 32'h406, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);
    xfer(1'b0, 32'h3, 32'h0, 4'h0, 32'h0, 1'b0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
